// File: rtl/lvds_align_ctrl.sv
// Word-alignment controller: pulses bitslip until the deserialized word shows the training
// pattern for MATCH_CNT consecutive cycles. Define LVDS_ALIGN_RETRY_EN for automatic retry after FAIL.
module lvds_align_ctrl #(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] PATTERN     = 8'hA5,
   parameter int               SETTLE      = 4,
   parameter int               MATCH_CNT   = 16,
   parameter int               RETRY_DELAY = 256
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [WIDTH-1:0]       train_data,
   output logic                   bitslip,
   output logic                   busy,
   output logic                   locked,
   output logic                   fail,
   output logic [$clog2(WIDTH):0] slip_count
);
   localparam int SCW = $clog2(WIDTH) + 1;
   localparam int STW = $clog2(SETTLE + 1);
   localparam int MCW = $clog2(MATCH_CNT + 1);
   localparam logic [SCW-1:0] SLIP_LAST   = SCW'(WIDTH - 1);
   localparam logic [STW-1:0] SETTLE_DONE = STW'(SETTLE);
   localparam logic [MCW-1:0] MATCH_LAST  = MCW'(MATCH_CNT - 1);

   if (SETTLE < 1 || MATCH_CNT < 1 || RETRY_DELAY < 1) begin : g_param_check
      $error("lvds_align_ctrl: SETTLE, MATCH_CNT and RETRY_DELAY must all be at least 1");
   end

   typedef enum logic [2:0] {
      ST_IDLE, ST_SETTLE, ST_CHECK, ST_SLIP, ST_LOCKED, ST_FAIL
   } state_t;

   state_t           state_q;
   logic [STW-1:0]   settle_cnt_q;
   logic [MCW-1:0]   match_cnt_q;
   logic [SCW-1:0]   slip_cnt_q;
   logic             bitslip_q;
   logic             busy_q;
   logic             locked_q;
   logic             fail_q;
   logic             start_ok;
   logic             restart;

   // start is only honoured from a resting state; while busy it is dropped, not queued
   assign start_ok = start && (state_q == ST_IDLE || state_q == ST_LOCKED || state_q == ST_FAIL);

`ifdef LVDS_ALIGN_RETRY_EN
   localparam int RTW = $clog2(RETRY_DELAY + 1);
   localparam logic [RTW-1:0] RETRY_LAST = RTW'(RETRY_DELAY - 1);
   logic [RTW-1:0] retry_cnt_q;

   assign restart = start_ok || (state_q == ST_FAIL && retry_cnt_q == RETRY_LAST);

   always_ff @(posedge clk) begin
      if (reset || state_q != ST_FAIL) begin
         retry_cnt_q <= '0;
      end else begin
         retry_cnt_q <= retry_cnt_q + 1'b1;
      end
   end
`else
   assign restart = start_ok;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         settle_cnt_q <= '0;
         match_cnt_q  <= '0;
         slip_cnt_q   <= '0;
         bitslip_q    <= 1'b0;
         busy_q       <= 1'b0;
         locked_q     <= 1'b0;
         fail_q       <= 1'b0;
      end else begin
         bitslip_q <= 1'b0;
         if (restart) begin
            state_q      <= ST_SETTLE;
            settle_cnt_q <= '0;
            match_cnt_q  <= '0;
            slip_cnt_q   <= '0;
            busy_q       <= 1'b1;
            locked_q     <= 1'b0;
            fail_q       <= 1'b0;
         end else begin
            case (state_q)
               ST_SETTLE: begin
                  if (settle_cnt_q == SETTLE_DONE) begin
                     state_q     <= ST_CHECK;
                     match_cnt_q <= '0;
                  end else begin
                     settle_cnt_q <= settle_cnt_q + 1'b1;
                  end
               end
               ST_CHECK: begin
                  if (train_data == PATTERN) begin
                     if (match_cnt_q == MATCH_LAST) begin
                        state_q  <= ST_LOCKED;
                        locked_q <= 1'b1;
                        busy_q   <= 1'b0;
                     end else begin
                        match_cnt_q <= match_cnt_q + 1'b1;
                     end
                  end else begin
                     match_cnt_q <= '0;
                     if (slip_cnt_q == SLIP_LAST) begin
                        state_q <= ST_FAIL;
                        fail_q  <= 1'b1;
                        busy_q  <= 1'b0;
                     end else begin
                        state_q    <= ST_SLIP;
                        bitslip_q  <= 1'b1;
                        slip_cnt_q <= slip_cnt_q + 1'b1;
                     end
                  end
               end
               ST_SLIP: begin
                  // the slip cycle itself is the first settling cycle of the new position
                  state_q      <= ST_SETTLE;
                  settle_cnt_q <= STW'(1);
               end
               ST_IDLE, ST_LOCKED, ST_FAIL: ;
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign bitslip    = bitslip_q;
   assign busy       = busy_q;
   assign locked     = locked_q;
   assign fail       = fail_q;
   assign slip_count = slip_cnt_q;

endmodule

// File: tb/tb_lvds_align_ctrl.sv
// Bench for lvds_align_ctrl: vector table, reset-during-slip sequence and random runs, all
// checked every cycle against an edge-timeline model of the alignment procedure.
`timescale 1ns/1ps
module tb_lvds_align_ctrl;
   localparam int         WIDTH       = 8;
   localparam logic [7:0] PAT         = 8'hA5;
   localparam int         SETTLE      = 4;
   localparam int         MATCH_CNT   = 16;
   localparam int         RETRY_DELAY = 256;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] train_data;
   logic       bitslip;
   logic       busy;
   logic       locked;
   logic       fail;
   logic [3:0] slip_count;

   int n_assert = 0;
   int n_fail   = 0;

   // timeline model results
   int m_slip_e[8];
   int m_ns;
   int m_end;
   bit m_lock;

   lvds_align_ctrl #(
      .WIDTH(WIDTH), .PATTERN(PAT), .SETTLE(SETTLE),
      .MATCH_CNT(MATCH_CNT), .RETRY_DELAY(RETRY_DELAY)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .train_data(train_data),
      .bitslip(bitslip), .busy(busy), .locked(locked), .fail(fail),
      .slip_count(slip_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      logic [7:0] w0;
      bit         rot;
      int         glitch;
      int         extra;
      int         exp_end;
      bit         exp_lock;
      int         exp_slips;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string what, input int e, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at edge %0d: got %0h, expected %0h", what, e, act, exp);
      end
   endtask

   function automatic logic [7:0] rotl(input logic [7:0] w, input int n);
      logic [7:0] r;
      r = w;
      for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
      return r;
   endfunction

   // Deserializer output: rotates one bit per slip; an optional single-edge glitch inverts it.
   function automatic logic [7:0] word_at(input logic [7:0] w0, input bit rot, input int gl,
                                          input int e, input int s);
      logic [7:0] w;
      w = rot ? rotl(w0, s) : w0;
      if (gl != 0 && e == gl) w = ~w;
      return w;
   endfunction

   // First compare lands at edge 1+SETTLE+1; every failed position costs a slip plus SETTLE
   // cycles before the next compare; lock needs MATCH_CNT consecutive matching compares.
   task automatic model(input logic [7:0] w0, input bit rot, input int gl);
      int e;
      int run;
      e      = 1 + SETTLE + 1;
      run    = 0;
      m_ns   = 0;
      m_end  = -1;
      m_lock = 1'b0;
      while (m_end < 0 && e < 2000) begin
         if (word_at(w0, rot, gl, e, m_ns) == PAT) begin
            run++;
            if (run == MATCH_CNT) begin
               m_end  = e;
               m_lock = 1'b1;
            end
            e++;
         end else if (m_ns == WIDTH - 1) begin
            m_end = e;
         end else begin
            m_slip_e[m_ns] = e;
            m_ns++;
            run = 0;
            e += SETTLE + 2;
         end
      end
   endtask

   task automatic run_case(input string tag, input logic [7:0] w0, input bit rot, input int gl,
                           input int extra, input int exp_end, input bit exp_lock,
                           input int exp_slips, input bit use_tab);
      int seen_end;
      int tb_slips;
      int last;
      int exp_sc;
      bit exp_bs;
      seen_end = -1;
      tb_slips = 0;
      model(w0, rot, gl);
      last       = m_end + 3;
      train_data = word_at(w0, rot, gl, 0, 0);
      start      = 1'b1;
      for (int e = 0; e <= last; e++) begin
         @(posedge clk);
         #1;
         exp_bs = 1'b0;
         exp_sc = 0;
         for (int i = 0; i < m_ns; i++) begin
            if (m_slip_e[i] == e) exp_bs = 1'b1;
            if (m_slip_e[i] <= e) exp_sc++;
         end
         chk({tag, " bitslip"}, e, bitslip, exp_bs);
         chk({tag, " slip_count"}, e, slip_count, exp_sc);
         chk({tag, " busy"}, e, busy, (e < m_end) ? 1 : 0);
         chk({tag, " locked"}, e, locked, (m_lock && e >= m_end) ? 1 : 0);
         chk({tag, " fail"}, e, fail, (!m_lock && e >= m_end) ? 1 : 0);
         if (bitslip === 1'b1) tb_slips++;
         if (seen_end < 0 && (locked === 1'b1 || fail === 1'b1)) seen_end = e;
         start      = (e + 1 == extra);
         train_data = word_at(w0, rot, gl, e + 1, tb_slips);
      end
      start = 1'b0;
      if (use_tab) begin
         chk({tag, " end edge"}, last, seen_end, exp_end);
         chk({tag, " slips"}, last, tb_slips, exp_slips);
         chk({tag, " final lock"}, last, locked, exp_lock);
      end else begin
         chk({tag, " end edge"}, last, seen_end, m_end);
         chk({tag, " slips"}, last, tb_slips, m_ns);
      end
      $display("%s: w0=%h rot=%0d glitch=%0d extra_start=%0d -> %s at edge %0d after %0d slips",
               tag, w0, rot, gl, extra, (locked === 1'b1) ? "lock" : "no lock", seen_end, tb_slips);
   endtask

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      train_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("reset bitslip", 0, bitslip, 0);
      chk("reset busy", 0, busy, 0);
      chk("reset locked", 0, locked, 0);
      chk("reset fail", 0, fail, 0);
      chk("reset slip_count", 0, slip_count, 0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      vecs[0] = '{"pattern_now",    8'hA5, 1'b0, 0,  0,  21, 1'b1, 0};
      vecs[1] = '{"rotated_by_3",   8'hB4, 1'b1, 0,  0,  39, 1'b1, 3};
      vecs[2] = '{"all_zero",       8'h00, 1'b0, 0,  0,  48, 1'b0, 7};
      vecs[3] = '{"glitch_check10", 8'hA5, 1'b0, 15, 0,  36, 1'b1, 1};
      vecs[4] = '{"start_in_settle",8'hA5, 1'b0, 0,  3,  21, 1'b1, 0};
      vecs[5] = '{"start_in_check", 8'hA5, 1'b0, 0,  12, 21, 1'b1, 0};
      foreach (vecs[i]) begin
         run_case(vecs[i].tag, vecs[i].w0, vecs[i].rot, vecs[i].glitch, vecs[i].extra,
                  vecs[i].exp_end, vecs[i].exp_lock, vecs[i].exp_slips, 1'b1);
      end

`ifdef LVDS_ALIGN_RETRY_EN
      run_case("retry_zero", 8'h00, 1'b0, 0, 0, 48, 1'b0, 7, 1'b1);
      // bench now sits at edge 51; the retry fires RETRY_DELAY edges after fail (edge 48)
      repeat (RETRY_DELAY - 4) @(posedge clk);
      #1;
      chk("retry wait fail", 303, fail, 1);
      chk("retry wait busy", 303, busy, 0);
      @(posedge clk);
      #1;
      chk("retry busy", 304, busy, 1);
      chk("retry fail", 304, fail, 0);
      chk("retry slip_count", 304, slip_count, 0);
      $display("retry: busy=%0b slip_count=%0d at edge 304", busy, slip_count);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
`endif

      // reset sampled on the edge that ends the bitslip pulse
      train_data = 8'hB4;
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("rst_slip pulse", 6, bitslip, 1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_slip bitslip", 7, bitslip, 0);
      chk("rst_slip busy", 7, busy, 0);
      chk("rst_slip slip_count", 7, slip_count, 0);
      chk("rst_slip locked", 7, locked, 0);
      chk("rst_slip fail", 7, fail, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_slip idle busy", 10, busy, 0);
      chk("rst_slip idle bitslip", 10, bitslip, 0);
      $display("reset_on_slip: outputs cleared, block idle");
      run_case("relock_after_reset", 8'hA5, 1'b0, 0, 0, 21, 1'b1, 0, 1'b1);

      for (int i = 0; i < 24; i++) begin
         logic [7:0] w;
         bit         r;
         int         g;
         int         x;
         if ($urandom_range(0, 1) == 1) begin
            w = rotl(PAT, 8 - int'($urandom_range(0, 7)));
            r = 1'b1;
         end else begin
            w = 8'($urandom);
            r = 1'($urandom_range(0, 1));
         end
         g = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(6, 45));
         x = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 20));
         run_case("random", w, r, g, x, 0, 1'b0, 0, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/lvds_align_ctrl.md
# lvds_align_ctrl

Word-alignment controller for the LVDS input deserializer. It runs one alignment sequence per request. While the transmitter sends a fixed training word, the block issues single-cycle bitslip pulses to the deserializer until the synchronized parallel word matches the pattern for a programmable number of consecutive cycles. It sits after the input synchronizer. It drives the deserializer bitslip control and reports lock or failure status to the register interface.

## Interface
Parameters:
- WIDTH, 8, deserialized word width in bits
- PATTERN, 8'hA5, training word; WIDTH bits wide
- SETTLE, 4, cycles waited after start or after each bitslip before comparing; must be ≥1
- MATCH_CNT, 16, consecutive matching words required for lock; must be ≥1
- RETRY_DELAY, 256, idle cycles between FAIL and automatic retry; used only with the retry macro

Ports:
- clk  in  1  single clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin alignment
- train_data  in  WIDTH  synchronized deserializer word
- bitslip  out  1  one-cycle pulse to the deserializer bitslip input
- busy  out  1  high while alignment is in progress
- locked  out  1  high once alignment has succeeded
- fail  out  1  high once all slip positions are exhausted
- slip_count  out  $clog2(WIDTH)+1  number of bitslips issued in the current sequence

## Operation
- All outputs are registered. Reset values: bitslip=0, busy=0, locked=0, fail=0, slip_count=0. State=IDLE, all counters 0.
- FSM states: IDLE, SETTLE, CHECK, SLIP, LOCKED, FAIL.
- IDLE
  - start=1: clear slip_count, settle counter and match counter; go to SETTLE; busy=1.
- SETTLE
  - Count SETTLE cycles, then go to CHECK with the match counter at 0.
  - train_data is ignored here.
- CHECK
  - Each cycle compare train_data==PATTERN over the full width.
  - Match: increment the match counter. When the count reaches MATCH_CNT, go to LOCKED (locked=1, busy=0).
  - Mismatch with slip_count < WIDTH-1: go to SLIP.
  - Mismatch with slip_count == WIDTH-1: go to FAIL (fail=1, busy=0).
  - Any mismatch resets the match counter; lock always requires consecutive matches.
- SLIP
  - Exactly one cycle; bitslip=1 and slip_count increments.
  - Next state is SETTLE.
- LOCKED
  - Outputs hold until start or reset. train_data is not monitored.
  - start=1: clear locked and slip_count; same transition as from IDLE.
- FAIL
  - slip_count holds WIDTH-1.
  - start=1: clear fail and slip_count; same transition as from IDLE.
- start while busy=1 is ignored and is not queued.
- locked and fail are never high together. busy is never high together with either of them.
- reset at any cycle, including mid-SETTLE or during the bitslip pulse, returns the block to IDLE with reset values on the next edge. No partial pulse may follow.

## Timing
- Edge 0 samples start. busy=1 from the edge-0 output onward.
- If the pattern is present immediately, locked rises at edge 1+SETTLE+MATCH_CNT after edge 0, which is edge 21 with defaults. busy falls on the same edge.
- Each failed position costs (cycles in CHECK until the mismatch) + 1 SLIP cycle + SETTLE cycles.
- The bitslip pulse is exactly 1 cycle. Consecutive pulses are at least SETTLE+2 cycles apart.
- Worst-case fail with defaults: 7 slips with the mismatch on the first CHECK cycle. fail asserts at edge 1 + 7×(4+1+1) + 4 + 1 = 48.

## Configuration
- Macro LVDS_ALIGN_RETRY_EN.
- Defined:
  - After entering FAIL, count RETRY_DELAY cycles with fail=1, then clear fail and slip_count, set busy=1 and go to SETTLE, as if start had been received.
  - start during the delay triggers the restart immediately.
  - Retries repeat indefinitely.
- Undefined: FAIL is sticky until start or reset, and the retry counter is not implemented.

## Test plan
- train_data=8'hA5 constant, pulse start → locked=1 at edge 21; bitslip never asserted; slip_count=0; fail=0.
- Bench model rotates the word one bit per bitslip, correct after 3 slips → exactly 3 bitslip pulses, each SETTLE+2 cycles apart or more; then locked=1, slip_count=3.
- train_data=8'h00 constant → 7 bitslip pulses, then fail=1 and busy=0 at edge 48, slip_count=7. With LVDS_ALIGN_RETRY_EN, busy=1 again 256 cycles later and slip_count=0.
- Pattern correct but a single mismatch injected at the 10th CHECK cycle → one bitslip pulse and the match counter restarts. After the bench restores the pattern following the slip, locked asserts once there have been 16 fresh consecutive matches.
- reset=1 asserted on the SLIP cycle → on the next edge bitslip=0, busy=0, slip_count=0, and the state is IDLE. A later start relocks normally.
- start pulsed again while busy=1 → ignored; lock timing is identical to the single-start case.
